// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: ALU opcodes, execute-stage states and the
// control bundle carried alongside each instruction through the pipeline.
package cpu_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_MUL = 2'b10;
  localparam logic [1:0] ALU_AND = 2'b11;

  typedef enum logic {
    EX_IDLE,
    EX_MUL
  } ex_state_t;

  typedef struct packed {
    logic wbs;
    logic wme;
    logic mm;
    logic wm;
    logic am;
    logic ni;
  } ctrl_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, LSB first.
// product is the accumulator after the current step, so it is final while last=1.
module seq_multiplier #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             last,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned CntBits = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic               r_busy;
  logic [CntBits-1:0] r_cnt;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   w_addend;

  assign w_addend = r_mplier[0] ? r_mcand : '0;
  assign product  = r_acc + w_addend;
  assign busy     = r_busy;
  assign last     = r_busy && (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (abort) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (start) begin
      r_busy   <= 1'b1;
      r_cnt    <= CntBits'(WIDTH - 1);
      r_mcand  <= a;
      r_mplier <= b;
      r_acc    <= '0;
    end else if (r_busy) begin
      r_acc    <= product;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ADD/SUB/AND, iterative MUL that stalls the front end.
// The output registers form the Execute/Memory pipeline register.
module execute_stage
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned REG_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_in,
  input  logic [1:0]          ALUop_in,
  input  logic                wbs_in,
  input  logic                wme_in,
  input  logic                mm_in,
  input  logic                wm_in,
  input  logic                am_in,
  input  logic                ni_in,
  input  logic [WIDTH-1:0]    srcA_in,
  input  logic [WIDTH-1:0]    srcB_in,
  input  logic [REG_BITS-1:0] rd_in,
  input  logic                flush_in,
  output logic                stall_out,
  output logic                valid_out,
  output logic [WIDTH-1:0]    result_out,
  output logic                zero_out,
  output logic                neg_out,
  output logic                wbs_out,
  output logic                wme_out,
  output logic                mm_out,
  output logic                wm_out,
  output logic                am_out,
  output logic                ni_out,
  output logic [REG_BITS-1:0] rd_out
);

  ex_state_t           r_state;
  logic                r_valid;
  logic [WIDTH-1:0]    r_result;
  logic                r_zero;
  logic                r_neg;
  ctrl_t               r_ctrl;
  logic [REG_BITS-1:0] r_rd;
  ctrl_t               r_mul_ctrl;
  logic [REG_BITS-1:0] r_mul_rd;

  ctrl_t            w_ctrl_in;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] w_next_result;
  logic [WIDTH-1:0] w_product;
  logic             w_mul_busy;
  logic             w_mul_last;
  logic             w_accept_mul;

  assign w_ctrl_in    = {wbs_in, wme_in, mm_in, wm_in, am_in, ni_in};
  assign w_accept_mul = (r_state == EX_IDLE) && valid_in && (ALUop_in == ALU_MUL);

  always_comb begin
    w_alu = '0;
    case (ALUop_in)
      ALU_ADD: w_alu = srcA_in + srcB_in;
      ALU_SUB: w_alu = srcA_in - srcB_in;
      ALU_AND: w_alu = srcA_in & srcB_in;
      default: w_alu = '0;
    endcase
  end

  assign w_next_result = (r_state == EX_MUL) ? w_product : w_alu;

  // Flush overrides everything; in MUL the stall drops on the counter==0 cycle.
  assign stall_out = !flush_in &&
                     (w_accept_mul || ((r_state == EX_MUL) && w_mul_busy && !w_mul_last));

  seq_multiplier #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (w_accept_mul && !flush_in),
    .abort  (flush_in),
    .a      (srcA_in),
    .b      (srcB_in),
    .busy   (w_mul_busy),
    .last   (w_mul_last),
    .product(w_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= EX_IDLE;
      r_valid    <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_neg      <= 1'b0;
      r_ctrl     <= '0;
      r_rd       <= '0;
      r_mul_ctrl <= '0;
      r_mul_rd   <= '0;
    end else begin
      // Default is a bubble; result and flags hold.
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_rd    <= '0;
      if (flush_in) begin
        r_state <= EX_IDLE;
      end else begin
        case (r_state)
          EX_IDLE: begin
            if (w_accept_mul) begin
              r_mul_ctrl <= w_ctrl_in;
              r_mul_rd   <= rd_in;
              r_state    <= EX_MUL;
            end else if (valid_in) begin
              r_valid  <= 1'b1;
              r_result <= w_next_result;
              r_zero   <= (w_next_result == '0);
              r_neg    <= w_next_result[WIDTH-1];
              r_ctrl   <= w_ctrl_in;
              r_rd     <= rd_in;
            end
          end
          EX_MUL: begin
            if (w_mul_last) begin
              r_valid  <= 1'b1;
              r_result <= w_next_result;
              r_zero   <= (w_next_result == '0);
              r_neg    <= w_next_result[WIDTH-1];
              r_ctrl   <= r_mul_ctrl;
              r_rd     <= r_mul_rd;
              r_state  <= EX_IDLE;
            end
          end
          default: r_state <= EX_IDLE;
        endcase
      end
    end
  end

  assign valid_out  = r_valid;
  assign result_out = r_result;
  assign zero_out   = r_zero;
  assign neg_out    = r_neg;
  assign wbs_out    = r_ctrl.wbs;
  assign wme_out    = r_ctrl.wme;
  assign mm_out     = r_ctrl.mm;
  assign wm_out     = r_ctrl.wm;
  assign am_out     = r_ctrl.am;
  assign ni_out     = r_ctrl.ni;
  assign rd_out     = r_rd;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: stimulus pushes expected results,
// a negedge monitor pops and compares whenever valid_out is seen.
module tb_execute_stage;

  localparam int W = 16;
  localparam int R = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid_in;
  logic [1:0]   ALUop_in;
  logic         wbs_in, wme_in, mm_in, wm_in, am_in, ni_in;
  logic [W-1:0] srcA_in, srcB_in;
  logic [R-1:0] rd_in;
  logic         flush_in;
  logic         stall_out, valid_out, zero_out, neg_out;
  logic [W-1:0] result_out;
  logic         wbs_out, wme_out, mm_out, wm_out, am_out, ni_out;
  logic [R-1:0] rd_out;

  typedef struct packed {
    logic [W-1:0] result;
    logic         zero;
    logic         neg;
    logic [5:0]   ctrl;
    logic [R-1:0] rd;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   stalls;

  execute_stage #(.WIDTH(W), .REG_BITS(R)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ALUop_in(ALUop_in),
    .wbs_in(wbs_in), .wme_in(wme_in), .mm_in(mm_in), .wm_in(wm_in), .am_in(am_in),
    .ni_in(ni_in), .srcA_in(srcA_in), .srcB_in(srcB_in), .rd_in(rd_in),
    .flush_in(flush_in), .stall_out(stall_out), .valid_out(valid_out),
    .result_out(result_out), .zero_out(zero_out), .neg_out(neg_out),
    .wbs_out(wbs_out), .wme_out(wme_out), .mm_out(mm_out), .wm_out(wm_out),
    .am_out(am_out), .ni_out(ni_out), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [5:0] out_ctrl();
    return {wbs_out, wme_out, mm_out, wm_out, am_out, ni_out};
  endfunction

  function automatic logic [63:0] all_outs();
    return {stall_out, valid_out, result_out, zero_out, neg_out, out_ctrl(), rd_out};
  endfunction

  task automatic push(input logic [W-1:0] res, input logic [5:0] c, input logic [R-1:0] rd);
    exp_t e;
    e.result = res;
    e.zero   = (res == '0);
    e.neg    = res[W-1];
    e.ctrl   = c;
    e.rd     = rd;
    q.push_back(e);
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [5:0] c, input logic [R-1:0] rd);
    valid_in = v;
    ALUop_in = op;
    srcA_in  = a;
    srcB_in  = b;
    {wbs_in, wme_in, mm_in, wm_in, am_in, ni_in} = c;
    rd_in    = rd;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 2'b00, '0, '0, 6'b0, '0);
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [5:0] c, input logic [R-1:0] rd);
    drive(1'b1, op, a, b, c, rd);
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  // Hold a MUL upstream while stalled, then let the completion edge pass.
  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [5:0] c, input logic [R-1:0] rd, output int n);
    drive(1'b1, 2'b10, a, b, c, rd);
    #1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!stall_out) break;
      n++;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  // Monitor: compare every presented result, and require clean bubbles otherwise.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (valid_out) begin
          if (q.size() == 0) begin
            check("unexpected_valid", {result_out, out_ctrl(), rd_out}, 0);
          end else begin
            exp_t e;
            e = q.pop_front();
            check("result", result_out, e.result);
            check("flags", {zero_out, neg_out}, {e.zero, e.neg});
            check("ctrl", out_ctrl(), e.ctrl);
            check("rd", rd_out, e.rd);
          end
        end else begin
          check("bubble_ctrl_rd", {out_ctrl(), rd_out}, 0);
        end
      end
    end
  end

  initial begin
    // Reset with every input high.
    rst_n = 1'b0;
    valid_in = 1'b1; ALUop_in = 2'b11; flush_in = 1'b1;
    {wbs_in, wme_in, mm_in, wm_in, am_in, ni_in} = 6'h3F;
    srcA_in = '1; srcB_in = '1; rd_in = '1;
    #2;
    check("reset_outputs", all_outs(), 0);
    idle_inputs();
    flush_in = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_reset_idle", all_outs(), 0);

    // Single-cycle ops.
    push(16'd8, 6'b100000, 4'd2);
    issue(2'b00, 16'd5, 16'd3, 6'b100000, 4'd2);
    push(16'hFFFE, 6'b000001, 4'd3);
    issue(2'b01, 16'd3, 16'd5, 6'b000001, 4'd3);
    push(16'h0000, 6'b001000, 4'd4);
    issue(2'b11, 16'h00F0, 16'h0F0F, 6'b001000, 4'd4);

    // MUL 7*6 followed immediately by ADD 1+1.
    push(16'd42, 6'b010000, 4'd5);
    run_mul(16'd7, 16'd6, 6'b010000, 4'd5, stalls);
    check("mul_stall_cycles", stalls, 16);
    push(16'd2, 6'b100000, 4'd6);
    issue(2'b00, 16'd1, 16'd1, 6'b100000, 4'd6);

    // Truncated product, then a back-to-back MUL.
    push(16'h0000, 6'b100000, 4'd7);
    run_mul(16'h0100, 16'h0100, 6'b100000, 4'd7, stalls);
    check("mul_trunc_stalls", stalls, 16);
    push(16'hFFFF, 6'b000100, 4'd8);
    run_mul(16'hFFFF, 16'h0001, 6'b000100, 4'd8, stalls);
    check("mul_b2b_stalls", stalls, 16);
    repeat (2) @(posedge clk);
    #1;

    // Flush on the 5th cycle of a MUL.
    drive(1'b1, 2'b10, 16'd9, 16'd9, 6'b010000, 4'd9);
    repeat (4) @(posedge clk);
    #1;
    check("stall_before_flush", stall_out, 1'b1);
    flush_in = 1'b1;
    #1;
    check("flush_kills_stall", stall_out, 1'b0);
    @(posedge clk);
    #1;
    flush_in = 1'b0;
    idle_inputs();
    check("flush_bubble", {valid_out, wme_out}, 2'b00);
    push(16'd30, 6'b110000, 4'd10);
    issue(2'b00, 16'd10, 16'd20, 6'b110000, 4'd10);

    // valid_in=0 with controls asserted.
    drive(1'b0, 2'b00, 16'd1, 16'd2, 6'b110000, 4'd11);
    @(posedge clk);
    #1;
    check("invalid_bubble", {valid_out, wme_out, wbs_out}, 3'b000);
    idle_inputs();

    // Asynchronous reset in the middle of a MUL.
    drive(1'b1, 2'b10, 16'd3, 16'd3, 6'b010000, 4'd12);
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check("async_reset_mid_mul", all_outs(), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (24) @(posedge clk);
    #1;
    check("no_result_after_reset", valid_out, 1'b0);
    check("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the 5-stage pipeline. Consumes the decoded controls and operands held in the Decode/Execute pipeline register and performs the ALU operation.
- Add, sub and AND complete in one cycle. Multiply is iterative shift-add and stalls the front end until it finishes.
- Its output registers are the Execute/Memory pipeline register, so memory and writeback controls are emitted aligned with the result.

Parameters:
WIDTH, 16, datapath/operand width in bits
REG_BITS, 4, destination register index width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
valid_in  in  1  Decode/Execute register holds a real instruction
ALUop_in  in  2  00 ADD, 01 SUB, 10 MUL, 11 AND
wbs_in, wme_in, mm_in, wm_in, am_in, ni_in  in  1 each  control bits from decode, carried through to memory/writeback
srcA_in, srcB_in  in  WIDTH  operands
rd_in  in  REG_BITS  destination register
flush_in  in  1  synchronous squash of the stage (branch taken)
stall_out  out  1  hold the Fetch/Decode and Decode/Execute registers
valid_out  out  1  Execute/Memory register holds a real instruction
result_out  out  WIDTH  ALU result
zero_out, neg_out  out  1  result==0, result[WIDTH-1]
wbs_out, wme_out, mm_out, wm_out, am_out, ni_out  out  1 each  registered control copies
rd_out  out  REG_BITS  registered destination

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, multiplier counter 0. It takes effect immediately and aborts any multiply in progress.
- Latency, ADD/SUB/AND: 1 cycle. Inputs sampled at edge E0 appear on the outputs after E0 with valid_out=1.
- ADD/SUB are modulo 2^WIDTH; no carry or overflow output.
- Bubble rule: when an edge writes no real instruction, valid_out=0 and every control output plus rd_out is 0. This guarantees no spurious memory write or writeback. result_out and the flags hold their previous values.
- States:
  - IDLE: single-cycle ops execute directly.
  - MUL: iterative multiply in progress.
- IDLE with valid_in=1 and ALUop=MUL: stall_out=1 combinationally. At the edge:
  - capture operands, controls and rd;
  - set counter to WIDTH-1 and accumulator to 0;
  - go to MUL and emit a bubble.
- MUL: each edge performs one shift-add step (multiplier LSB first) and decrements the counter.
  - stall_out=1 while counter!=0 and 0 while counter==0.
  - At the edge with counter==0: low WIDTH bits of the product go to result_out; flags and captured controls are emitted with valid_out=1; state returns to IDLE.
  - The upstream register advances on that same edge, so the next instruction is presented in the following cycle.
- MUL timing: the operation occupies WIDTH+1 edges (E0..E_WIDTH), stall is high for WIDTH cycles, and the result is valid after E_WIDTH.
- Edges inside MUL other than the final one emit bubbles. valid_in and ALUop_in are ignored while in MUL.
- flush_in=1 at an edge has highest priority over completion and acceptance:
  - valid_out<=0 and controls cleared;
  - MUL aborts to IDLE, counter cleared;
  - stall_out is forced 0 combinationally in that cycle.
- valid_in=0: bubble emitted, no state change.
- Back-to-back MUL: the second MUL is accepted in the cycle after the first completes, with no extra gap.
- AND is bitwise. Flags are always computed from the value written to result_out.

Decomposition:
- Shared package cpu_pkg:
  - ALUop constants ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_MUL=2'b10, ALU_AND=2'b11;
  - enum ex_state_t {EX_IDLE, EX_MUL};
  - a packed struct for the six control bits, reused by the neighbouring pipeline registers.
- One sub-module: seq_multiplier.
  - Ports: clk, rst_n, start, abort, a, b, busy, last, product.
  - Contains the counter and shift-add datapath; execute_stage keeps the state machine and pipeline register.

Test Plan:
- Reset check: rst_n=0 with all inputs driven to 1 -> every output 0 and stall_out=0; release, no activity -> outputs stay 0.
- ADD 5+3 with wbs_in=1, rd_in=2 -> after 1 edge: valid_out=1, result_out=8, zero_out=0, wbs_out=1, rd_out=2. Then SUB 3-5 -> result_out=16'hFFFE, neg_out=1. Then AND 16'h00F0 & 16'h0F0F -> result_out=0, zero_out=1.
- MUL 7*6 (WIDTH=16) with wme_in=1 -> stall_out high for exactly 16 cycles and wme_out=0 during them. After edge 16 from acceptance: result_out=42, valid_out=1, wme_out=1. An ADD 1+1 presented next -> result 2 one edge later.
- MUL 16'h0100*16'h0100 -> result_out=0 (truncated), zero_out=1.
- flush_in pulsed at the 5th cycle of a MUL -> stall_out drops immediately, next output is a bubble with valid_out=0 and wme_out=0, state returns to IDLE. A following ADD completes normally.
- valid_in=0 with wme_in=1 and wbs_in=1 -> valid_out=0 and wme_out=wbs_out=0. Separately, rst_n pulsed low mid-MUL -> all outputs 0 immediately and no result emitted afterwards.
